// File: rtl/serial_to_parallel_param.sv
// serial_to_parallel_param
// Frame-synchronised serial-to-parallel converter. Hunts for an 8-bit sync
// pattern, then assembles WIDTH data bits (MSB- or LSB-first) into a registered
// parallel word offered to the consumer with a valid/ready handshake.
// Optional feature: define PARITY_CHECK_EN to consume one even-parity bit after
// each data word and drop the word (PAR_ERR pulse) on a mismatch.
module serial_to_parallel_param #(
  parameter int         WIDTH     = 32,
  parameter bit         MSB_FIRST = 1'b1,
  parameter logic [7:0] SYNC_WORD = 8'hA5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             S_IN,
  input  logic             S_EN,
  input  logic             P_READY,
  output logic             P_VALID,
  output logic [WIDTH-1:0] P_OUT,
  output logic             BUSY,
  output logic             OVERRUN,
  output logic             PAR_ERR
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;
`else
  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [7:0]       sr_shift;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] bit_idx;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] p_out_q, p_out_d;
  logic             p_valid_q, p_valid_d;
  logic             overrun_q, overrun_d;
  logic             complete;
`ifdef PARITY_CHECK_EN
  logic             par_acc_q, par_acc_d;
  logic             par_err_q, par_err_d;
`endif

  // Shadow index of the current data bit: first bit lands at the MSB or LSB end.
  always_comb begin
    bit_idx = cnt_q;
    if (MSB_FIRST) begin
      bit_idx = CNT_LAST - cnt_q;
    end
  end

  // Next-state logic: sync hunt, data assembly, optional parity, output handshake.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    sr_shift  = {sr_q[6:0], S_IN};
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    p_out_d   = p_out_q;
    p_valid_d = p_valid_q;
    overrun_d = 1'b0;
    complete  = 1'b0;
`ifdef PARITY_CHECK_EN
    par_acc_d = par_acc_q;
    par_err_d = 1'b0;
`endif

    // A plain accept retires the held word; a completion below may reload it.
    if (p_valid_q && P_READY) begin
      p_valid_d = 1'b0;
    end

    case (state_q)
      HUNT: begin
        if (S_EN) begin
          if (sr_shift == SYNC_WORD) begin
            // Sync register is cleared so the next hunt starts from scratch
            // and can never match on bits that belonged to this frame.
            state_d = DATA;
            cnt_d   = '0;
            sr_d    = '0;
`ifdef PARITY_CHECK_EN
            par_acc_d = 1'b0;
`endif
          end else begin
            sr_d = sr_shift;
          end
        end
      end

      DATA: begin
        if (S_EN) begin
          shadow_d[bit_idx] = S_IN;
`ifdef PARITY_CHECK_EN
          par_acc_d = par_acc_q ^ S_IN;
`endif
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
`ifdef PARITY_CHECK_EN
            state_d = PAR;
`else
            state_d  = HUNT;
            complete = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

`ifdef PARITY_CHECK_EN
      PAR: begin
        if (S_EN) begin
          state_d = HUNT;
          // Even parity: data bits XOR parity bit must be zero.
          if (par_acc_q ^ S_IN) begin
            par_err_d = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = HUNT;
      end
    endcase

    // A finished word is published only if the output slot is free or is being
    // accepted this cycle; otherwise it is dropped and the held word is kept.
    if (complete) begin
      if (!p_valid_q || P_READY) begin
        p_out_d   = shadow_d;
        p_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Control and output registers; reset discards any partial frame.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      cnt_q     <= '0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_acc_q <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      p_out_q   <= p_out_d;
      p_valid_q <= p_valid_d;
      overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
      par_acc_q <= par_acc_d;
      par_err_q <= par_err_d;
`endif
    end
  end

  // Assembly shadow: every bit is rewritten before a word completes, so no reset.
  always_ff @(posedge CLK) begin
    shadow_q <= shadow_d;
  end

  assign P_OUT   = p_out_q;
  assign P_VALID = p_valid_q;
  assign OVERRUN = overrun_q;
  assign BUSY    = (state_q != HUNT);
`ifdef PARITY_CHECK_EN
  assign PAR_ERR = par_err_q;
`else
  assign PAR_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel_param.sv
// Testbench for serial_to_parallel_param: a 32-bit MSB-first instance (a) and an
// 8-bit LSB-first instance (b). Works with or without PARITY_CHECK_EN.
module tb_serial_to_parallel_param;

  logic        clk;
  logic        rst_a, s_in_a, s_en_a, rdy_a;
  logic        vld_a, busy_a, ovr_a, perr_a;
  logic [31:0] pout_a;
  logic        rst_b, s_in_b, s_en_b, rdy_b;
  logic        vld_b, busy_b, ovr_b, perr_b;
  logic [7:0]  pout_b;

  int checks   = 0;
  int failures = 0;

  serial_to_parallel_param #(.WIDTH(32), .MSB_FIRST(1'b1), .SYNC_WORD(8'hA5)) dut_a (
    .CLK(clk), .RESET(rst_a), .S_IN(s_in_a), .S_EN(s_en_a), .P_READY(rdy_a),
    .P_VALID(vld_a), .P_OUT(pout_a), .BUSY(busy_a), .OVERRUN(ovr_a), .PAR_ERR(perr_a)
  );

  serial_to_parallel_param #(.WIDTH(8), .MSB_FIRST(1'b0), .SYNC_WORD(8'hA5)) dut_b (
    .CLK(clk), .RESET(rst_b), .S_IN(s_in_b), .S_EN(s_en_b), .P_READY(rdy_b),
    .P_VALID(vld_b), .P_OUT(pout_b), .BUSY(busy_b), .OVERRUN(ovr_b), .PAR_ERR(perr_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          sel;   // 0 = instance a (32-bit MSB-first), 1 = instance b (8-bit LSB-first)
    logic [31:0] seq;   // serial sequence, first bit = seq[n-1]
    logic [31:0] exp;   // expected P_OUT
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input bit sel, input bit b);
    if (sel) begin
      s_in_b = b;
      s_en_b = 1'b1;
    end else begin
      s_in_a = b;
      s_en_a = 1'b1;
    end
    @(negedge clk);
    s_en_a = 1'b0;
    s_en_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_seq(input bit sel, input logic [31:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(sel, seq[i]);
  endtask

  task automatic send_sync(input bit sel);
    send_seq(sel, 32'h0000_00A5, 8);
  endtask

  task automatic send_parity(input bit sel, input logic [31:0] seq);
`ifdef PARITY_CHECK_EN
    drive_bit(sel, ^seq);
`else
    if (sel && seq[0]) begin
      // no parity bit is consumed in this build
    end
`endif
  endtask

  task automatic send_frame(input bit sel, input logic [31:0] seq);
    send_sync(sel);
    send_seq(sel, seq, sel ? 8 : 32);
    send_parity(sel, seq);
  endtask

  initial begin
    vecs[0] = '{sel: 1'b0, seq: 32'hDEADBEEF, exp: 32'hDEADBEEF};
    vecs[1] = '{sel: 1'b0, seq: 32'h00000000, exp: 32'h00000000};
    vecs[2] = '{sel: 1'b0, seq: 32'h80000001, exp: 32'h80000001};
    vecs[3] = '{sel: 1'b0, seq: 32'hFFFFFFFF, exp: 32'hFFFFFFFF};
    vecs[4] = '{sel: 1'b1, seq: 32'h00000080, exp: 32'h00000001};
    vecs[5] = '{sel: 1'b1, seq: 32'h000000C5, exp: 32'h000000A3};
    vecs[6] = '{sel: 1'b1, seq: 32'h00000012, exp: 32'h00000048};

    rst_a = 1'b1; s_in_a = 1'b0; s_en_a = 1'b0; rdy_a = 1'b1;
    rst_b = 1'b1; s_in_b = 1'b0; s_en_b = 1'b0; rdy_b = 1'b1;
    idle(2);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset state
    chk("rst_pout_a", pout_a, 0);
    chk("rst_vld_a", vld_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_ovr_a", ovr_a, 0);
    chk("rst_perr_a", perr_a, 0);
    chk("rst_pout_b", pout_b, 0);
    chk("rst_vld_b", vld_b, 0);
    chk("rst_busy_b", busy_b, 0);

    // Table-driven frames with the consumer always ready
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].sel, vecs[v].seq);
      if (vecs[v].sel) begin
        chk($sformatf("vec%0d_pout", v), pout_b, vecs[v].exp);
        chk($sformatf("vec%0d_vld", v), vld_b, 1);
        idle(1);
        chk($sformatf("vec%0d_vld_drop", v), vld_b, 0);
        chk($sformatf("vec%0d_ovr", v), ovr_b, 0);
      end else begin
        chk($sformatf("vec%0d_pout", v), pout_a, vecs[v].exp);
        chk($sformatf("vec%0d_vld", v), vld_a, 1);
        idle(1);
        chk($sformatf("vec%0d_vld_drop", v), vld_a, 0);
        chk($sformatf("vec%0d_ovr", v), ovr_a, 0);
      end
    end

    // 8-bit LSB-first with S_EN toggling: BUSY throughout data, S_EN=0 holds state
    send_sync(1'b1);
    for (int i = 7; i >= 0; i--) begin
      chk("tog_busy", busy_b, 1);
      drive_bit(1'b1, (i == 7));
      if (i > 0) idle(1);
    end
    send_parity(1'b1, 32'h80);
    chk("tog_pout", pout_b, 8'h01);
    chk("tog_vld", vld_b, 1);
    chk("tog_busy_end", busy_b, 0);
    idle(1);

    // Back-to-back frames while the consumer stalls: second word is dropped
    rdy_a = 1'b0;
    send_frame(1'b0, 32'h12345678);
    chk("ovr_first_pout", pout_a, 32'h12345678);
    chk("ovr_first_vld", vld_a, 1);
    chk("ovr_first_ovr", ovr_a, 0);
    send_frame(1'b0, 32'hCAFEF00D);
    chk("ovr_pulse", ovr_a, 1);
    chk("ovr_pout_kept", pout_a, 32'h12345678);
    chk("ovr_vld_kept", vld_a, 1);
    idle(1);
    chk("ovr_pulse_end", ovr_a, 0);
    chk("ovr_pout_stable", pout_a, 32'h12345678);
    rdy_a = 1'b1;
    idle(1);
    chk("accept_vld_clear", vld_a, 0);
    chk("accept_pout_retained", pout_a, 32'h12345678);

    // Reset mid-frame discards the partial word
    send_sync(1'b0);
    send_seq(1'b0, 32'h000003FF, 10);
    chk("midrst_busy", busy_a, 1);
    rst_a = 1'b1;
    idle(1);
    rst_a = 1'b0;
    chk("midrst_pout", pout_a, 0);
    chk("midrst_vld", vld_a, 0);
    chk("midrst_busy_clr", busy_a, 0);
    chk("midrst_ovr", ovr_a, 0);
    send_frame(1'b0, 32'h0000FFFF);
    chk("postrst_pout", pout_a, 32'h0000FFFF);
    chk("postrst_vld", vld_a, 1);
    chk("postrst_ovr", ovr_a, 0);
    chk("postrst_perr", perr_a, 0);
    idle(1);

`ifdef PARITY_CHECK_EN
    // Parity mismatch: 8'h03 has even parity 0, so parity bit 1 is an error
    send_sync(1'b1);
    send_seq(1'b1, 32'h000000C0, 8);
    drive_bit(1'b1, 1'b1);
    chk("par_err_pulse", perr_b, 1);
    chk("par_err_vld", vld_b, 0);
    idle(1);
    chk("par_err_end", perr_b, 0);
    send_sync(1'b1);
    send_seq(1'b1, 32'h000000C0, 8);
    drive_bit(1'b1, 1'b0);
    chk("par_ok_pout", pout_b, 8'h03);
    chk("par_ok_vld", vld_b, 1);
    chk("par_ok_perr", perr_b, 0);
    idle(1);
`else
    chk("noparity_perr_a", perr_a, 0);
    chk("noparity_perr_b", perr_b, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
